svc_rv_mem_arb: RTL and testbench
=================================

Name: svc_rv_mem_arb

Overview:
Arbiter that shares one single-port, BRAM-timed unified memory between the svc_rv instruction-fetch port and data port. Data accesses normally win. A starvation counter forces an instruction fetch through after STARVE_MAX consecutive lost cycles. When that happens, the displaced data access is captured and replayed on the next cycle, with dmem_stall asserted to the core. The block sits between svc_rv and the SoC memory, replacing separate imem/dmem BRAMs.

Parameters:
XLEN, 32, data width; memory word width.
AW, 32, byte-address width of all address ports.
STARVE_MAX, 2, consecutive cycles a pending fetch may lose before it is forced; 0 means fetch always wins.

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
imem_arvalid  input  1  fetch request; core holds it and imem_araddr until accepted
imem_araddr  input  AW  fetch byte address
imem_arready  output  1  fetch accepted this cycle
imem_rdata  output  XLEN  fetch data; valid when imem_rvalid
imem_rvalid  output  1  fetch data valid, one cycle after acceptance
dmem_ren  input  1  data read request
dmem_raddr  input  AW  data read address
dmem_rdata  output  XLEN  read data; valid in the first non-stalled cycle after dmem_ren
dmem_we  input  1  data write request
dmem_waddr  input  AW  write address
dmem_wdata  input  XLEN  write data
dmem_wstrb  input  XLEN/8  byte strobes
dmem_stall  output  1  core must freeze; dmem inputs ignored while high
mem_ren  output  1  memory read enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  XLEN  memory write data
mem_wstrb  output  XLEN/8  memory strobes
mem_rdata  input  XLEN  memory read data, registered, 1-cycle latency

Behaviour:
- Reset (reset synchronous, active-high; clock clock): state=NORMAL, starve_cnt=0, replay register cleared, rd_src=NONE. While reset is high: imem_rvalid=0, dmem_stall=0, imem_arready=0, mem_ren=0, mem_we=0.
- Reset asserted during REPLAY discards the captured op. No memory access is issued.
- At most one memory access per cycle. mem_ren and mem_we are never both high.
- dmem_ren and dmem_we asserted together is illegal. Writes take precedence.
- Memory grant priority in NORMAL:
  - forced fetch, when imem_arvalid && starve_cnt==STARVE_MAX; otherwise
  - dmem write or read; otherwise
  - fetch.
- Fetch grant drives mem_ren=1, mem_addr=imem_araddr, imem_arready=1, and sets rd_src=I for the next cycle.
- Dmem read grant sets rd_src=D. Write grant drives mem_we, mem_wdata, mem_wstrb; no return.
- Displacement on a forced fetch with a dmem op present:
  - The op (addr, wdata, wstrb, kind) is captured and state goes to REPLAY.
  - In REPLAY (exactly one cycle): dmem_stall=1, the captured op is issued, imem_arready=0, then state returns to NORMAL.
  - For a replayed read, dmem_rdata=mem_rdata in the cycle after REPLAY (stall low).
  - dmem_stall is never high for more than one consecutive cycle.
- starve_cnt:
  - increments, saturating at STARVE_MAX, each cycle imem_arvalid && !imem_arready (REPLAY cycles included);
  - clears on fetch acceptance or when imem_arvalid is low.
  - Width is clog2(STARVE_MAX+1), minimum 1.
- Return path: imem_rvalid = (rd_src==I), registered. imem_rdata and dmem_rdata both wire to mem_rdata and are meaningful only in their return cycle.
- No fetch/write hazard checking. The core orders self-modifying code with FENCE.I.
- STARVE_MAX=0: a pending fetch always wins. Every colliding dmem op is replayed with one stall cycle.

Test Plan:
- Fetch only, araddr 0x0,0x4,0x8 on consecutive cycles -> arready=1 each cycle; rvalid=1 one cycle later with mem_rdata; dmem_stall stays 0.
- dmem_ren raddr 0x100 colliding with fetch 0x10, starve_cnt=0 -> mem_addr=0x100, arready=0, starve_cnt=1; next cycle fetch 0x10 granted, dmem_rdata valid, no stall.
- Fetch 0x20 held while dmem_ren hits 3 consecutive cycles, STARVE_MAX=2 -> cycle 3 mem_addr=0x20, arready=1; cycle 4 dmem_stall=1 with replayed read issued; cycle 5 stall=0 and dmem_rdata=replayed data.
- Forced fetch colliding with dmem_we waddr 0x200, wdata 0xDEADBEEF, wstrb 0xF -> replay cycle has mem_we=1, same addr/data/strb, dmem_stall=1 for exactly one cycle.
- reset asserted in the REPLAY cycle -> mem_we=mem_ren=0, dmem_stall=0, imem_rvalid=0 next cycle; starve_cnt=0.
- STARVE_MAX=0, simultaneous fetch 0x40 and dmem_ren 0x300 -> fetch granted; next cycle stall=1 and read issued; dmem_rdata valid the cycle after.

Source files
------------

// File: rtl/svc_rv_mem_arb.sv
// Shares one single-port, 1-cycle-latency memory between the svc_rv fetch and data ports.
// Data normally wins. A fetch starved for STARVE_MAX cycles is forced and the displaced data op is replayed.
//   state  | meaning
//   NORMAL | arbitrate fetch vs data each cycle
//   REPLAY | issue the displaced data op, stall the core
module svc_rv_mem_arb #(
  parameter int XLEN       = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_arvalid,
  input  logic [AW-1:0]     imem_araddr,
  output logic              imem_arready,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_rvalid,
  input  logic              dmem_ren,
  input  logic [AW-1:0]     dmem_raddr,
  output logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_we,
  input  logic [AW-1:0]     dmem_waddr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN/8-1:0] dmem_wstrb,
  output logic              dmem_stall,
  output logic              mem_ren,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {NORMAL, REPLAY} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_I, SRC_D} src_t;

  state_t              state, state_next;
  src_t                rd_src, rd_src_next;
  logic [SW-1:0]       starve_cnt, starve_next;
  logic                capture;
  logic                rep_we;
  logic [AW-1:0]       rep_addr;
  logic [XLEN-1:0]     rep_wdata;
  logic [XLEN/8-1:0]   rep_wstrb;
  logic                forced;

  assign forced = imem_arvalid && (starve_cnt == STARVE_LIM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= NORMAL;
      rd_src     <= SRC_NONE;
      starve_cnt <= '0;
      rep_we     <= 1'b0;
      rep_addr   <= '0;
      rep_wdata  <= '0;
      rep_wstrb  <= '0;
    end else begin
      state      <= state_next;
      rd_src     <= rd_src_next;
      starve_cnt <= starve_next;
      if (capture) begin
        rep_we    <= dmem_we;
        rep_addr  <= dmem_we ? dmem_waddr : dmem_raddr;
        rep_wdata <= dmem_wdata;
        rep_wstrb <= dmem_wstrb;
      end
    end
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    rd_src_next = imem_arready ? SRC_I : (mem_ren ? SRC_D : SRC_NONE);
    starve_next = '0;
    if (imem_arvalid && !imem_arready)
      starve_next = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
    case (state)
      NORMAL: if (forced && (dmem_we || dmem_ren)) begin
        state_next = REPLAY;
        capture    = 1'b1;
      end
      REPLAY:  state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_comb begin
    imem_arready = 1'b0;
    dmem_stall   = 1'b0;
    mem_ren      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    if (!reset) begin
      case (state)
        NORMAL: begin
          if (forced || (imem_arvalid && !dmem_we && !dmem_ren)) begin
            imem_arready = 1'b1;
            mem_ren      = 1'b1;
            mem_addr     = imem_araddr;
          end else if (dmem_we) begin
            mem_we    = 1'b1;
            mem_addr  = dmem_waddr;
            mem_wdata = dmem_wdata;
            mem_wstrb = dmem_wstrb;
          end else if (dmem_ren) begin
            mem_ren  = 1'b1;
            mem_addr = dmem_raddr;
          end
        end
        REPLAY: begin
          dmem_stall = 1'b1;
          mem_we     = rep_we;
          mem_ren    = !rep_we;
          mem_addr   = rep_addr;
          mem_wdata  = rep_wdata;
          mem_wstrb  = rep_wstrb;
        end
        default: ;
      endcase
    end
  end

  assign imem_rvalid = (rd_src == SRC_I) && !reset;
  assign imem_rdata  = mem_rdata;
  assign dmem_rdata  = mem_rdata;

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Directed bench for svc_rv_mem_arb: one instance with STARVE_MAX=2, one with STARVE_MAX=0, sharing stimulus.
module tb_svc_rv_mem_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        dmem_ren, dmem_we;
  logic [31:0] dmem_raddr, dmem_waddr, dmem_wdata;
  logic [3:0]  dmem_wstrb;

  logic        arready, rvalid, stall, mren, mwe;
  logic [31:0] irdata, drdata, maddr, mwdata, mrdata;
  logic [3:0]  mwstrb;
  logic        arready0, rvalid0, stall0, mren0, mwe0;
  logic [31:0] irdata0, drdata0, maddr0, mwdata0, mrdata0;
  logic [3:0]  mwstrb0;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  svc_rv_mem_arb #(.XLEN(32), .AW(32), .STARVE_MAX(2)) u_dut (
    .clock(clock), .reset(reset),
    .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(arready),
    .imem_rdata(irdata), .imem_rvalid(rvalid),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(drdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_stall(stall), .mem_ren(mren), .mem_we(mwe), .mem_addr(maddr),
    .mem_wdata(mwdata), .mem_wstrb(mwstrb), .mem_rdata(mrdata));

  svc_rv_mem_arb #(.XLEN(32), .AW(32), .STARVE_MAX(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(arready0),
    .imem_rdata(irdata0), .imem_rvalid(rvalid0),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(drdata0),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_stall(stall0), .mem_ren(mren0), .mem_we(mwe0), .mem_addr(maddr0),
    .mem_wdata(mwdata0), .mem_wstrb(mwstrb0), .mem_rdata(mrdata0));

  // Memory returns an address-derived word so each return cycle identifies what was read.
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always @(posedge clock) begin
    if (mren)  mrdata  <= f(maddr);
    if (mren0) mrdata0 <= f(maddr0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    imem_arvalid = 0; imem_araddr = 0;
    dmem_ren = 0; dmem_raddr = 0;
    dmem_we = 0; dmem_waddr = 0; dmem_wdata = 0; dmem_wstrb = 0;
  endtask

  initial begin
    mrdata = 0; mrdata0 = 0;
    idle();
    reset = 1;
    imem_arvalid = 1;
    tick(); tick();
    #1;
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_mem_ren", {31'd0, mren}, 0);
    chk("rst_mem_we", {31'd0, mwe}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    idle(); reset = 0;
    tick();

    // fetch-only stream
    imem_arvalid = 1; imem_araddr = 32'h0; #1;
    chk("f0_arready", {31'd0, arready}, 1);
    chk("f0_addr", maddr, 32'h0);
    tick();
    chk("f0_rvalid", {31'd0, rvalid}, 1);
    chk("f0_rdata", irdata, f(32'h0));
    imem_araddr = 32'h4; #1;
    chk("f4_arready", {31'd0, arready}, 1);
    chk("f4_addr", maddr, 32'h4);
    tick();
    chk("f4_rdata", irdata, f(32'h4));
    imem_araddr = 32'h8; #1;
    chk("f8_addr", maddr, 32'h8);
    tick();
    chk("f8_rvalid", {31'd0, rvalid}, 1);
    chk("f8_rdata", irdata, f(32'h8));
    idle(); #1;
    chk("f_stall", {31'd0, stall}, 0);
    tick();
    chk("f_rvalid_off", {31'd0, rvalid}, 0);

    // single collision, data wins
    imem_arvalid = 1; imem_araddr = 32'h10;
    dmem_ren = 1; dmem_raddr = 32'h100; #1;
    chk("c_addr", maddr, 32'h100);
    chk("c_arready", {31'd0, arready}, 0);
    tick();
    chk("c_starve", {30'd0, u_dut.starve_cnt}, 1);
    chk("c_drdata", drdata, f(32'h100));
    chk("c_rvalid", {31'd0, rvalid}, 0);
    dmem_ren = 0; #1;
    chk("c_stall", {31'd0, stall}, 0);
    chk("c_farready", {31'd0, arready}, 1);
    chk("c_faddr", maddr, 32'h10);
    tick();
    chk("c_irdata", irdata, f(32'h10));
    idle(); tick();

    // starvation forces fetch, read replayed
    imem_arvalid = 1; imem_araddr = 32'h20;
    dmem_ren = 1; dmem_raddr = 32'h104; #1;
    chk("s1_addr", maddr, 32'h104);
    tick();
    dmem_raddr = 32'h108; #1;
    chk("s2_addr", maddr, 32'h108);
    chk("s2_arready", {31'd0, arready}, 0);
    tick();
    chk("s2_starve", {30'd0, u_dut.starve_cnt}, 2);
    dmem_raddr = 32'h10C; #1;
    chk("s3_addr", maddr, 32'h20);
    chk("s3_arready", {31'd0, arready}, 1);
    chk("s3_stall", {31'd0, stall}, 0);
    tick();
    chk("s4_rvalid", {31'd0, rvalid}, 1);
    chk("s4_irdata", irdata, f(32'h20));
    imem_arvalid = 0; #1;
    chk("s4_stall", {31'd0, stall}, 1);
    chk("s4_ren", {31'd0, mren}, 1);
    chk("s4_addr", maddr, 32'h10C);
    chk("s4_arready", {31'd0, arready}, 0);
    tick();
    idle(); #1;
    chk("s5_stall", {31'd0, stall}, 0);
    chk("s5_drdata", drdata, f(32'h10C));
    tick();

    // forced fetch displaces a write
    imem_arvalid = 1; imem_araddr = 32'h24;
    dmem_ren = 1; dmem_raddr = 32'h110;
    tick(); tick();
    dmem_ren = 0; dmem_we = 1; dmem_waddr = 32'h200;
    dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF; #1;
    chk("w_faddr", maddr, 32'h24);
    chk("w_we_held", {31'd0, mwe}, 0);
    tick();
    imem_arvalid = 0; #1;
    chk("w_we", {31'd0, mwe}, 1);
    chk("w_ren", {31'd0, mren}, 0);
    chk("w_addr", maddr, 32'h200);
    chk("w_wdata", mwdata, 32'hDEADBEEF);
    chk("w_wstrb", {28'd0, mwstrb}, 32'hF);
    chk("w_stall", {31'd0, stall}, 1);
    tick();
    idle(); #1;
    chk("w_stall_off", {31'd0, stall}, 0);
    chk("w_we_off", {31'd0, mwe}, 0);
    tick();

    // reset during replay drops the captured write
    imem_arvalid = 1; imem_araddr = 32'h28;
    dmem_ren = 1; dmem_raddr = 32'h114;
    tick(); tick();
    dmem_ren = 0; dmem_we = 1; dmem_waddr = 32'h204;
    dmem_wdata = 32'h12345678; dmem_wstrb = 4'h3;
    tick();
    idle(); reset = 1; #1;
    chk("r_we", {31'd0, mwe}, 0);
    chk("r_ren", {31'd0, mren}, 0);
    chk("r_stall", {31'd0, stall}, 0);
    chk("r_rvalid", {31'd0, rvalid}, 0);
    tick();
    chk("r_rvalid2", {31'd0, rvalid}, 0);
    chk("r_starve", {30'd0, u_dut.starve_cnt}, 0);
    reset = 0; #1;
    chk("r_we2", {31'd0, mwe}, 0);
    chk("r_stall2", {31'd0, stall}, 0);
    tick();

    // STARVE_MAX=0: fetch always wins, data op replayed
    imem_arvalid = 1; imem_araddr = 32'h40;
    dmem_ren = 1; dmem_raddr = 32'h300; #1;
    chk("z_arready", {31'd0, arready0}, 1);
    chk("z_faddr", maddr0, 32'h40);
    chk("z_stall", {31'd0, stall0}, 0);
    tick();
    chk("z_rvalid", {31'd0, rvalid0}, 1);
    chk("z_irdata", irdata0, f(32'h40));
    idle(); #1;
    chk("z_rstall", {31'd0, stall0}, 1);
    chk("z_rren", {31'd0, mren0}, 1);
    chk("z_raddr", maddr0, 32'h300);
    chk("z_rarready", {31'd0, arready0}, 0);
    tick();
    chk("z_drdata", drdata0, f(32'h300));
    chk("z_stall_off", {31'd0, stall0}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
